uart_rx_param: RTL and testbench

- Parametrised successor to the fixed 8N1 UART receiver.
- Configurable data width, parity, stop-bit count and baud/clock ratio.
- 16x-oversampled majority-vote sampling, false-start rejection, parity/framing/break detection, and a held-data read handshake with overrun flag.
- Sits between the board RX pin and the command/data consumer logic on the single system clock.

---
 rtl/uart_rx_param.sv | 211 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param -- parametrised oversampling UART receiver.
//
// Receives one frame: a start bit, DATA_BITS payload bits (LSB first), an
// optional parity bit, then STOP_BITS stop bits. Each bit is decided by a
// 2-of-3 majority vote of the samples taken at ticks OVERSAMPLE/2-1,
// OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit. The received frame is held
// until the next frame completes.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx         asynchronous serial input, idle high
//   rd         one-cycle consumer acknowledge, clears ready and overrun
//   data       last received payload
//   ready      high while unread data is held
//   parity_err parity mismatch on the frame held in data
//   frame_err  a stop bit was sampled low on the frame held in data
//   break_det  one-cycle pulse when payload, parity and first stop were all 0
//   overrun    sticky, a frame completed while ready was still high
//   state_dbg  FSM state: 0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP
//
// Handshake: ready rises on the edge that loads data/parity_err/frame_err.
// A cycle with rd=1 and ready=1 clears ready and overrun on the next edge;
// rd while ready=0 is ignored. When a frame completes in the same cycle as
// rd, the completion wins: new data loads, ready stays 1, overrun is 0.
module uart_rx_param #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 rd,
    output logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic [2:0]           state_dbg
);

    // Clocks per oversampling tick, rounded to nearest.
    localparam int DIV   = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BC_W  = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    // tick_cnt holds ticks already elapsed in the bit, so the tick numbered
    // n within the bit is seen while tick_cnt == n-1.
    localparam logic [OS_W-1:0]  SMP_A    = OS_W'(OVERSAMPLE / 2 - 2);
    localparam logic [OS_W-1:0]  SMP_B    = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  SMP_C    = OS_W'(OVERSAMPLE / 2);
    localparam logic [BC_W-1:0]  BIT_LAST = BC_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic             ODD       = (PARITY == 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                state;
    logic                  rx_meta, rx_s;
    logic [DIV_W-1:0]      div_cnt;
    logic [OS_W-1:0]       tick_cnt;
    logic [BC_W-1:0]       bit_cnt;
    logic                  stop_idx;
    logic                  samp_a, samp_b;
    logic [DATA_BITS-1:0]  shift;
    logic                  par_bad, par_bit, frame_bad, stop1_low;
    // armed: the line has been seen high in IDLE since the last frame, so a
    // low level is a genuine start edge and not a held break or leftover bit.
    logic                  armed;

    logic tick, maj, start_edge;

    assign tick       = (div_cnt == DIV_LAST);
    assign maj        = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    assign start_edge = (state == ST_IDLE) && armed && !rx_s;
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            rx_meta    <= 1'b1;
            rx_s       <= 1'b1;
            div_cnt    <= '0;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            stop_idx   <= 1'b0;
            samp_a     <= 1'b0;
            samp_b     <= 1'b0;
            shift      <= '0;
            par_bad    <= 1'b0;
            par_bit    <= 1'b0;
            frame_bad  <= 1'b0;
            stop1_low  <= 1'b0;
            armed      <= 1'b0;
            data       <= '0;
            ready      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            break_det <= 1'b0;

            if (rd && ready) begin
                ready   <= 1'b0;
                overrun <= 1'b0;
            end

            // Free-running divider, re-phased to the detected start edge.
            if (start_edge || tick) div_cnt <= '0;
            else                    div_cnt <= div_cnt + 1'b1;

            if (tick) tick_cnt <= (tick_cnt == OS_LAST) ? '0 : tick_cnt + 1'b1;

            if (tick && tick_cnt == SMP_A) samp_a <= rx_s;
            if (tick && tick_cnt == SMP_B) samp_b <= rx_s;

            case (state)
                ST_IDLE: begin
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state     <= ST_START;
                        tick_cnt  <= '0;
                        bit_cnt   <= '0;
                        stop_idx  <= 1'b0;
                        par_bad   <= 1'b0;
                        par_bit   <= 1'b0;
                        frame_bad <= 1'b0;
                        stop1_low <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (tick_cnt == SMP_C && maj) begin
                            // Glitch shorter than half a bit: drop it silently.
                            state <= ST_IDLE;
                            armed <= 1'b0;
                        end else if (tick_cnt == OS_LAST) begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (tick_cnt == SMP_C) begin
                            shift <= {maj, shift[DATA_BITS-1:1]};
                        end else if (tick_cnt == OS_LAST) begin
                            if (bit_cnt == BIT_LAST)
                                state <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                            else
                                bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        if (tick_cnt == SMP_C) begin
                            par_bit <= maj;
                            par_bad <= ODD ? ~(^shift ^ maj) : (^shift ^ maj);
                        end else if (tick_cnt == OS_LAST) begin
                            state <= ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (tick_cnt == SMP_C) begin
                            if (stop_idx == STOP_LAST) begin
                                // Complete mid-stop-bit so a back-to-back
                                // start edge is never missed.
                                data       <= shift;
                                parity_err <= par_bad;
                                frame_err  <= frame_bad | ~maj;
                                break_det  <= (shift == '0) && !par_bit &&
                                              (stop_idx ? stop1_low : ~maj);
                                ready      <= 1'b1;
                                overrun    <= ready & ~rd;
                                state      <= ST_IDLE;
                                armed      <= 1'b0;
                            end else begin
                                frame_bad <= frame_bad | ~maj;
                                stop1_low <= ~maj;
                            end
                        end else if (tick_cnt == OS_LAST) begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param. Two receivers share clock and reset:
//   a: 8 data bits, no parity, 1 stop bit
//   b: 8 data bits, even parity, 2 stop bits
// Both run at CLK_HZ/BAUD/OVERSAMPLE chosen so one bit is exactly 64 clocks.
// Delay units: one unit = 1 ns of the nominal 100 MHz clock.
module tb_uart_rx_param;

    localparam int CLK_HZ  = 100_000_000;
    localparam int BAUD    = 1_562_500;
    localparam int OS      = 16;
    localparam int DIV_REF = (CLK_HZ + BAUD * OS / 2) / (BAUD * OS);
    localparam int TICK_NS = DIV_REF * 10;
    localparam int BIT_NS  = TICK_NS * OS;
    localparam logic [2:0] IDLE_CODE = 3'd0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       rx_a, rx_b;
    logic       rd_a = 1'b0, rd_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic       ready_a, perr_a, ferr_a, brk_a, ovr_a;
    logic       ready_b, perr_b, ferr_b, brk_b, ovr_b;
    logic [2:0] st_a, st_b;

    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
                    .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rx(rx_a), .rd(rd_a), .data(data_a),
        .ready(ready_a), .parity_err(perr_a), .frame_err(ferr_a),
        .break_det(brk_a), .overrun(ovr_a), .state_dbg(st_a));

    uart_rx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS),
                    .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .rx(rx_b), .rd(rd_b), .data(data_b),
        .ready(ready_b), .parity_err(perr_b), .frame_err(ferr_b),
        .break_det(brk_b), .overrun(ovr_b), .state_dbg(st_b));

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Expected response per frame: {break_det, frame_err, parity_err, data}.
    logic [10:0] exp_a[$];
    logic [10:0] exp_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Reference model: the outcome of a frame from the bits put on the line.
    function automatic logic [10:0] model(input logic [7:0] d, input bit has_par,
                                          input bit par, input bit two_stop,
                                          input bit s1, input bit s2);
        logic perr, ferr, brk;
        perr = has_par && (((^d) ^ par) != 1'b0);   // even parity
        ferr = !s1 || (two_stop && !s2);
        brk  = (d == 8'h00) && (!has_par || !par) && !s1;
        return {brk, ferr, perr, d};
    endfunction

    // ---------------- drivers ----------------
    task automatic send_a(input logic [7:0] d, input bit s1, input bit push);
        if (push) exp_a.push_back(model(d, 0, 0, 0, s1, 1));
        rx_a = 1'b0; #(BIT_NS);
        for (int i = 0; i < 8; i++) begin rx_a = d[i]; #(BIT_NS); end
        rx_a = s1; #(BIT_NS);
        rx_a = 1'b1;
    endtask

    task automatic send_b(input logic [7:0] d, input bit par, input bit s1,
                          input bit s2, input bit push);
        if (push) exp_b.push_back(model(d, 1, par, 1, s1, s2));
        rx_b = 1'b0; #(BIT_NS);
        for (int i = 0; i < 8; i++) begin rx_b = d[i]; #(BIT_NS); end
        rx_b = par; #(BIT_NS);
        rx_b = s1;  #(BIT_NS);
        rx_b = s2;  #(BIT_NS);
        rx_b = 1'b1;
    endtask

    // ---------------- consumers ----------------
    bit auto_rd_a = 1'b1, auto_rd_b = 1'b1;
    bit rd_req_a  = 1'b0;

    always @(negedge clk) begin
        if (rd_req_a) begin
            rd_a     = 1'b1;
            rd_req_a = 1'b0;
        end else if (auto_rd_a && ready_a && !rd_a) rd_a = 1'b1;
        else rd_a = 1'b0;
    end

    always @(negedge clk) begin
        if (auto_rd_b && ready_b && !rd_b) rd_b = 1'b1;
        else rd_b = 1'b0;
    end

    // ---------------- monitors / scoreboard ----------------
    logic prev_ready_a = 1'b0, prev_ready_b = 1'b0;
    time  rise_t_a = 0;

    always @(negedge clk) begin
        logic [10:0] e;
        if (ready_a && !prev_ready_a) begin
            rise_t_a = $time;
            if (exp_a.size() == 0) begin
                total_cnt++;
                $display("FAIL a_unexpected_ready: got ready with data %0h, required no frame", data_a);
            end else begin
                e = exp_a.pop_front();
                check("a_data", data_a, e[7:0]);
                check("a_flags_brk_ferr_perr", {brk_a, ferr_a, perr_a}, e[10:8]);
            end
        end
        prev_ready_a = ready_a;
    end

    always @(negedge clk) begin
        logic [10:0] e;
        if (ready_b && !prev_ready_b) begin
            if (exp_b.size() == 0) begin
                total_cnt++;
                $display("FAIL b_unexpected_ready: got ready with data %0h, required no frame", data_b);
            end else begin
                e = exp_b.pop_front();
                check("b_data", data_b, e[7:0]);
                check("b_flags_brk_ferr_perr", {brk_b, ferr_b, perr_b}, e[10:8]);
            end
        end
        prev_ready_b = ready_b;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1, "time limit");
    end

    // ---------------- main sequence ----------------
    initial begin
        time t0;
        logic [7:0] d;
        bit s1, s2, par;

        rst  = 1'b0;
        rx_a = 1'b1;
        rx_b = 1'b1;
        #50;
        check("rst_data_a", data_a, 0);
        check("rst_ready_a", ready_a, 0);
        check("rst_flags_a", {perr_a, ferr_a, brk_a, ovr_a}, 0);
        check("rst_state_a", st_a, IDLE_CODE);
        check("rst_ready_b", ready_b, 0);
        check("rst_data_b", data_b, 0);
        #50;
        rst = 1'b1;
        #100;

        // First frame and its completion time (mid stop bit plus sync delay).
        t0 = $time;
        send_a(8'hD5, 1, 1);
        #(BIT_NS);
        check("a_ready_latency",
              (rise_t_a >= t0 + (19 * BIT_NS) / 2) &&
              (rise_t_a <= t0 + (19 * BIT_NS) / 2 + 2 * TICK_NS + 50), 1);

        // Overrun: two frames without reading.
        auto_rd_a = 1'b0;
        send_a(8'hD5, 1, 1);
        #(BIT_NS);
        send_a(8'h2B, 1, 0);
        #(BIT_NS);
        check("ovr_ready", ready_a, 1);
        check("ovr_flag", ovr_a, 1);
        check("ovr_data_overwritten", data_a, 8'h2B);
        rd_req_a = 1'b1;
        #40;
        check("rd_clears_ready", ready_a, 0);
        check("rd_clears_overrun", ovr_a, 0);
        check("rd_holds_data", data_a, 8'h2B);
        auto_rd_a = 1'b1;

        // False start: short low glitch is ignored.
        rx_a = 1'b0; #200; rx_a = 1'b1;
        #(BIT_NS);
        check("false_start_idle", st_a, IDLE_CODE);
        check("false_start_no_ready", ready_a, 0);
        send_a(8'h3C, 1, 1);
        #(BIT_NS);

        // Break: line low for 12 bit times.
        exp_a.push_back(model(8'h00, 0, 0, 0, 0, 1));
        rx_a = 1'b0; #(12 * BIT_NS); rx_a = 1'b1;
        #(2 * BIT_NS);
        check("break_no_second_ready", ready_a, 0);
        check("break_back_idle", st_a, IDLE_CODE);
        send_a(8'hA7, 1, 1);
        #(BIT_NS);

        // Reset in the 4th data bit with an unread frame held.
        auto_rd_a = 1'b0;
        send_a(8'h81, 1, 1);
        #(BIT_NS);
        fork
            send_a(8'hF0, 1, 0);
            begin
                #((4 * BIT_NS) + BIT_NS / 4);
                rst = 1'b0;
                #20;
                check("midrst_data", data_a, 0);
                check("midrst_ready", ready_a, 0);
                check("midrst_flags", {perr_a, ferr_a, brk_a, ovr_a}, 0);
                #180;
                rst = 1'b1;
            end
        join
        auto_rd_a = 1'b1;
        #(BIT_NS);
        check("midrst_no_ready", ready_a, 0);
        send_a(8'h55, 1, 1);
        #(BIT_NS);

        // Random frames on a, including back-to-back and bad stop bits.
        for (int n = 0; n < 12; n++) begin
            d  = 8'($urandom_range(0, 255));
            s1 = ($urandom_range(0, 5) != 0);
            send_a(d, s1, 1);
            if (s1) #($urandom_range(0, 2) * (BIT_NS / 2));
            else    #(BIT_NS / 2);
        end
        #(BIT_NS);

        // Receiver b: even parity, two stop bits.
        send_b(8'hA5, 1, 1, 1, 1);   // wrong parity
        #(BIT_NS);
        send_b(8'hA5, 0, 1, 1, 1);   // correct parity
        #(BIT_NS);
        exp_b.push_back(model(8'h00, 1, 0, 1, 0, 0));
        rx_b = 1'b0; #(13 * BIT_NS); rx_b = 1'b1;
        #(2 * BIT_NS);
        check("b_break_no_second_ready", ready_b, 0);
        for (int n = 0; n < 12; n++) begin
            d   = 8'($urandom_range(0, 255));
            par = (^d) ^ ($urandom_range(0, 3) == 0);
            s1  = ($urandom_range(0, 5) != 0);
            s2  = ($urandom_range(0, 5) != 0);
            send_b(d, par, s1, s2, 1);
            if (s2) #($urandom_range(0, 2) * (BIT_NS / 2));
            else    #(BIT_NS / 2);
        end
        #(2 * BIT_NS);

        check("a_queue_drained", exp_a.size(), 0);
        check("b_queue_drained", exp_b.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
